timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised bank of N independent down-counting timers behind one word-addressed register window, replacing the fixed pair of timers plus bridge decode. It sits on the CPU's peripheral bus next to data memory and drives one interrupt line per channel into the CPU's hardware-interrupt vector. It adds per-channel one-shot/auto-reload modes, sticky pending flags with write-1-to-clear, and channel-count/width generalisation.

## Interface
- N_CH, 2, number of timer channels (1..8)
- CNT_W, 32, counter/preset width in bits (1..32)
- BASE_ADDR, 32'h0000_7F00, byte base address; must be 16-byte aligned
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-low (asserted when 0)
- addr  in  30  word address, byte address bits [31:2]
- we  in  1  write strobe; meaningful only when hit=1
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- hit  out  1  addr falls inside [BASE_ADDR, BASE_ADDR+16*N_CH)
- irq  out  N_CH  per-channel interrupt, irq[i] = PEND[i] & IM[i]
- irq_any  out  1  OR of irq

## Operation
- Channel i occupies bytes BASE_ADDR+16*i ... +15: offset 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only), 0xC STATUS.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM; bits [31:4] read 0, writes ignored.
- PRESET, COUNT: CNT_W bits, zero-extended on read; wdata bits above CNT_W ignored. Writes to COUNT have no effect.
- STATUS: bit0 = PEND; writing 1 to bit0 clears PEND, writing 0 does nothing.
- Out-of-window access: hit=0, rdata=0, no register changes. Writes occur only when we=1 and hit=1.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
- IDLE: EN=1 -> LOAD; otherwise stay; COUNT holds its value.
- LOAD: COUNT <= PRESET; -> CNT (if EN=0, -> IDLE instead, no load).
- CNT: EN=0 -> IDLE (COUNT frozen); else COUNT==0 -> INT; else COUNT <= COUNT-1.
- INT: PEND <= 1 on entry edge; one-shot: EN <= 0, -> IDLE; auto-reload: -> LOAD.
- Counting is unsigned, no wrap: COUNT never decrements below 0.
- PRESET change during CNT does not affect the running count; used at next LOAD.
- Channels are fully independent; one channel's register write never touches another.

## Timing
- Reset (reset=0): all CTRL/PRESET/COUNT/PEND = 0, all FSMs IDLE, irq=0, irq_any=0; takes effect immediately, regardless of clk, including mid-count.
- Register writes take effect at the clk edge where we=1 and hit=1.
- Latency: EN written at edge E0 -> LOAD at E1 -> COUNT=PRESET at E2 -> COUNT reaches 0 at E2+P -> INT entered and PEND=1 at E2+P+1; irq rises P+3 cycles after E0 (P = PRESET).
- Auto-reload period: P+3 cycles (LOAD 1, CNT P+1, INT 1) between successive PEND sets.
- CPU write to CTRL in the same cycle as the FSM's one-shot EN clear: CPU value wins.
- STATUS clear in the same cycle as INT entry: set wins, PEND stays 1.
- IM change affects irq combinationally the cycle after its write edge; PEND is set regardless of IM.
- rdata reflects register contents before the current edge's update (no write-through bypass).

## Test plan
- Reset: hold reset=0 mid-operation with PEND=1 -> irq=0, all registers read 0, COUNT frozen at 0 after release.
- One-shot ch0: PRESET=5, CTRL=0x9 at edge E0 -> COUNT reads 5,4,..,0; irq[0] and irq_any high from edge E0+8; CTRL reads 0x8 afterwards; write STATUS=1 -> irq[0] low next cycle.
- Auto-reload ch1 (N_CH=2): PRESET=3, CTRL=0xB -> PEND set every 6 cycles; with clear each period, irq[1] pulses at period 6; ch0 registers unchanged.
- Mask: PRESET=2, CTRL=0x1 -> PEND=1 (STATUS reads 1), irq=0; then CTRL=0x8|0x0 via IM write -> irq high while PEND=1.
- Disable mid-count: PRESET=10, enable, write CTRL=0 when COUNT=6 -> COUNT stays 6, no PEND; re-enable -> reloads 10.
- Decode/boundaries: access BASE_ADDR+16*N_CH and BASE_ADDR-4 -> hit=0, rdata=0, no writes; write COUNT -> unchanged; STATUS clear coinciding with INT entry -> PEND remains 1; CNT_W=8, PRESET write 0x1FF -> reads 0xFF.

Source files
------------

// File: rtl/timer_bank.sv
// Bank of N_CH independent down-counting timers behind a word-addressed register window.
// Each channel: CTRL / PRESET / COUNT / STATUS, one-shot or auto-reload, sticky W1C pending flag.
module timer_bank #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [29:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            hit,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
    localparam logic [29:0] SPAN_W = 30'(4 * N_CH);

    logic [29:0]     off_w;
    logic [27:0]     sel_ch;
    logic [1:0]      sel_reg;
    logic            wr;
    logic [31:0]     ctrl_rd   [N_CH];
    logic [31:0]     preset_rd [N_CH];
    logic [31:0]     count_rd  [N_CH];
    logic [N_CH-1:0] pend;

    // The subtraction cannot wrap once addr >= BASE_W, so off_w bounds the window top.
    assign off_w   = addr - BASE_W;
    assign hit     = (addr >= BASE_W) && (off_w < SPAN_W);
    assign sel_ch  = off_w[29:2];
    assign sel_reg = off_w[1:0];
    assign wr      = we & hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic             en_q, im_q, pend_q;
        logic [1:0]       mode_q;
        logic [CNT_W-1:0] preset_q, count_q;
        logic             do_load, do_dec, set_pend, clr_en;
        logic             sel;

        assign sel = wr && (sel_ch == 28'(i));

        always_comb begin
            state_d  = state_q;
            do_load  = 1'b0;
            do_dec   = 1'b0;
            set_pend = 1'b0;
            clr_en   = 1'b0;
            case (state_q)
                IDLE: if (en_q) state_d = LOAD;
                LOAD: begin
                    if (en_q) begin
                        do_load = 1'b1;
                        state_d = CNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CNT: begin
                    if (!en_q) begin
                        state_d = IDLE;
                    end else if (count_q == '0) begin
                        set_pend = 1'b1;
                        state_d  = INT;
                    end else begin
                        do_dec = 1'b1;
                    end
                end
                INT: begin
                    if (mode_q == 2'b01) begin
                        state_d = LOAD;
                    end else begin
                        clr_en  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // CPU CTRL writes override the one-shot EN clear; a new PEND set overrides a W1C.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= IDLE;
                en_q     <= 1'b0;
                im_q     <= 1'b0;
                mode_q   <= '0;
                preset_q <= '0;
                count_q  <= '0;
                pend_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                if (sel && sel_reg == 2'd0) begin
                    en_q   <= wdata[0];
                    mode_q <= wdata[2:1];
                    im_q   <= wdata[3];
                end else if (clr_en) begin
                    en_q <= 1'b0;
                end
                if (sel && sel_reg == 2'd1) preset_q <= wdata[CNT_W-1:0];
                if (do_load) begin
                    count_q <= preset_q;
                end else if (do_dec) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (set_pend) begin
                    pend_q <= 1'b1;
                end else if (sel && sel_reg == 2'd3 && wdata[0]) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign ctrl_rd[i]   = {28'd0, im_q, mode_q, en_q};
        assign preset_rd[i] = 32'(preset_q);
        assign count_rd[i]  = 32'(count_q);
        assign pend[i]      = pend_q;
        assign irq[i]       = pend_q & im_q;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (sel_ch == 28'(c)) begin
                    case (sel_reg)
                        2'd0:    rdata = ctrl_rd[c];
                        2'd1:    rdata = preset_rd[c];
                        2'd2:    rdata = count_rd[c];
                        default: rdata = {31'd0, pend[c]};
                    endcase
                end
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed literal checks plus randomized bus traffic
// compared every cycle against a cycle-index behavioural model of each channel.
module tb_timer_bank;

    localparam int unsigned N = 2;
    localparam int unsigned W = 32;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam longint unsigned MASK = (64'd1 << W) - 1;
    localparam logic [31:0] C0 = BASE,      P0 = BASE + 4,  K0 = BASE + 8,  S0 = BASE + 12;
    localparam logic [31:0] C1 = BASE + 16, P1 = BASE + 20, K1 = BASE + 24, S1 = BASE + 28;

    logic          clk = 1'b0, reset = 1'b1, we = 1'b0;
    logic [29:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata, rdata8;
    logic          hit, hit8, irq_any, irq_any8;
    logic [N-1:0]  irq;
    logic [0:0]    irq8;

    timer_bank #(.N_CH(N), .CNT_W(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .hit(hit), .irq(irq), .irq_any(irq_any)
    );

    timer_bank #(.N_CH(1), .CNT_W(8), .BASE_ADDR(BASE)) dut8 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata8), .hit(hit8), .irq(irq8), .irq_any(irq_any8)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: m_k counts edges since the run started (0 = not running, 1 = load cycle,
    // 2..ld+2 = counting down from ld, ld+3 = interrupt cycle).
    int unsigned     m_en[N], m_mode[N], m_im[N], m_pre[N], m_cnt[N], m_pend[N];
    longint unsigned m_k[N], m_ld[N];
    bit              set_p[N];
    longint unsigned mb, moff;
    int              mch;

    function automatic bit m_hit(input logic [29:0] a);
        longint unsigned b;
        b = 0;
        b[31:0] = {a, 2'b00};
        return (b >= BASE) && (b < BASE + 16 * N);
    endfunction

    function automatic logic [31:0] m_read(input logic [29:0] a);
        longint unsigned b, o;
        int c;
        b = 0;
        b[31:0] = {a, 2'b00};
        if (b < BASE || b >= BASE + 16 * N) return '0;
        c = int'((b - BASE) / 16);
        o = (b - BASE) % 16;
        case (o)
            0:       return 32'(m_im[c] * 8 + m_mode[c] * 2 + m_en[c]);
            4:       return m_pre[c];
            8:       return m_cnt[c];
            default: return 32'(m_pend[c]);
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_pre[i] = 0;
                m_cnt[i] = 0; m_pend[i] = 0; m_k[i] = 0; m_ld[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                set_p[i] = 1'b0;
                if (m_k[i] == 0) begin
                    if (m_en[i] != 0) m_k[i] = 1;
                end else if (m_k[i] == 1) begin
                    if (m_en[i] != 0) begin
                        m_ld[i] = m_pre[i]; m_cnt[i] = m_pre[i]; m_k[i] = 2;
                    end else m_k[i] = 0;
                end else if (m_k[i] <= m_ld[i] + 2) begin
                    if (m_en[i] == 0) m_k[i] = 0;
                    else if (m_k[i] == m_ld[i] + 2) begin
                        m_k[i] = m_ld[i] + 3; m_pend[i] = 1; set_p[i] = 1'b1;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                        m_cnt[i] = 32'(m_ld[i] - (m_k[i] - 2));
                    end
                end else begin
                    if (m_mode[i] == 1) m_k[i] = 1;
                    else begin m_en[i] = 0; m_k[i] = 0; end
                end
            end
            mb = 0;
            mb[31:0] = {addr, 2'b00};
            if (we && mb >= BASE && mb < BASE + 16 * N) begin
                mch = int'((mb - BASE) / 16);
                moff = (mb - BASE) % 16;
                case (moff)
                    0: begin
                        m_en[mch] = wdata[0]; m_mode[mch] = wdata[2:1]; m_im[mch] = wdata[3];
                    end
                    4: m_pre[mch] = 32'(longint'(wdata) & MASK);
                    12: if (wdata[0] && !set_p[mch]) m_pend[mch] = 0;
                    default: ;
                endcase
            end
        end
    end

    logic [N-1:0] ei;
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < N; i++) ei[i] = (m_pend[i] != 0) && (m_im[i] != 0);
            check("hit", 32'(hit), 32'(m_hit(addr)));
            check("rdata", rdata, m_read(addr));
            check("irq", 32'(irq), 32'(ei));
            check("irq_any", 32'(irq_any), 32'(|ei));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a[31:2]; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] e);
        addr = a[31:2]; we = 1'b0;
        #1;
        check(n, rdata, e);
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return BASE + 32'(16 * $urandom_range(0, N - 1)) + 32'(4 * $urandom_range(0, 3));
        else if (r == 7) return BASE - 4;
        else if (r == 8) return BASE + 32'(16 * N);
        return $urandom;
    endfunction

    int prev, last, rises;
    logic [31:0] a_tmp;

    initial begin
        #2 reset = 1'b0;
        cmp_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // reset state
        rd_chk("rst_ctrl0", C0, 0); rd_chk("rst_pre0", P0, 0); tick();
        rd_chk("rst_cnt0", K0, 0); rd_chk("rst_st0", S0, 0); tick();
        rd_chk("rst_ctrl1", C1, 0); rd_chk("rst_pre1", P1, 0); tick();
        rd_chk("rst_cnt1", K1, 0); rd_chk("rst_st1", S1, 0);
        check("rst_irq", 32'(irq), 0);
        tick();

        // decode boundaries
        a_tmp = BASE + 32'(16 * N);
        addr = a_tmp[31:2]; #1;
        check("oow_hi_hit", 32'(hit), 0); check("oow_hi_rdata", rdata, 0);
        a_tmp = BASE - 4;
        addr = a_tmp[31:2]; #1;
        check("oow_lo_hit", 32'(hit), 0); check("oow_lo_rdata", rdata, 0);
        addr = S1[31:2]; #1;
        check("last_word_hit", 32'(hit), 1);
        check("n1_hit_ch1", 32'(hit8), 0);
        wr(BASE + 32'(16 * N), 32'hF);
        wr(BASE - 4, 32'hF);
        rd_chk("oow_wr_ctrl0", C0, 0); rd_chk("oow_wr_ctrl1", C1, 0);
        wr(K0, 32'h55);
        rd_chk("count_ro", K0, 0);
        wr(P0, 32'h1FF);
        check("w8_preset", rdata8, 32'hFF);
        rd_chk("w32_preset", P0, 32'h1FF);

        // one-shot ch0
        wr(P0, 5);
        wr(C0, 32'h9);
        addr = K0[31:2];
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k >= 2 && k <= 7) check("os_count", rdata, 32'(7 - k));
            check("os_irq0", 32'(irq[0]), (k >= 8) ? 1 : 0);
            check("os_any", 32'(irq_any), (k >= 8) ? 1 : 0);
        end
        tick();
        rd_chk("os_ctrl_after", C0, 32'h8);
        wr(S0, 1);
        check("os_clr_irq0", 32'(irq[0]), 0);
        check("os_clr_any", 32'(irq_any), 0);

        // auto-reload ch1
        wr(P1, 3);
        wr(C1, 32'hB);
        prev = 0; last = -1; rises = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (irq[1] && prev == 0) begin
                if (last < 0) check("ar_first", 32'(c), 6);
                else check("ar_period", 32'(c - last), 6);
                last = c;
                rises++;
            end
            prev = int'(irq[1]);
            if (irq[1]) begin addr = S1[31:2]; wdata = 1; we = 1'b1; end
            else we = 1'b0;
        end
        we = 1'b0;
        check("ar_rises", 32'(rises), 6);
        wr(C1, 0); tick(); tick(); wr(S1, 1);
        check("ar_off_irq", 32'(irq), 0);
        rd_chk("ar_ch0_pre", P0, 5); rd_chk("ar_ch0_ctrl", C0, 32'h8);
        tick();

        // mask
        wr(P0, 2);
        wr(C0, 32'h1);
        repeat (7) tick();
        rd_chk("mask_pend", S0, 1);
        check("mask_irq", 32'(irq[0]), 0);
        wr(C0, 32'h8);
        check("unmask_irq", 32'(irq[0]), 1);
        check("unmask_any", 32'(irq_any), 1);

        // asynchronous reset mid-operation
        wr(P1, 9);
        wr(C1, 1);
        repeat (4) tick();
        #1 reset = 1'b0;
        #1;
        check("areset_irq", 32'(irq), 0);
        check("areset_any", 32'(irq_any), 0);
        rd_chk("areset_cnt1", K1, 0); rd_chk("areset_st0", S0, 0); rd_chk("areset_ctrl0", C0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) tick();
        rd_chk("post_rst_cnt1", K1, 0); rd_chk("post_rst_cnt0", K0, 0);
        check("post_rst_irq", 32'(irq), 0);
        tick();

        // disable mid-count and re-enable
        wr(P0, 10);
        wr(C0, 1);
        repeat (5) tick();
        rd_chk("dis_cnt7", K0, 7);
        wr(C0, 0);
        rd_chk("dis_cnt6", K0, 6);
        repeat (3) tick();
        rd_chk("dis_hold6", K0, 6); rd_chk("dis_nopend", S0, 0);
        wr(C0, 1);
        tick(); tick();
        rd_chk("reen_cnt10", K0, 10);
        wr(C0, 0);

        // W1C coinciding with INT entry, CPU CTRL write coinciding with EN clear
        wr(P0, 0);
        wr(C0, 32'h9);
        tick(); tick();
        wr(S0, 1);
        rd_chk("clr_vs_set", S0, 1);
        check("clr_vs_set_irq", 32'(irq[0]), 1);
        wr(C0, 32'h9);
        rd_chk("cpu_wins_en", C0, 32'h9);
        wr(C0, 0);
        wr(S0, 1);
        rd_chk("final_clr", S0, 0);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            a_tmp = BASE + 32'(16 * $urandom_range(0, N - 1));
            we = 1'b0;
            if (r < 10) begin
                addr = a_tmp[31:2]; we = 1'b1;
                wdata = $urandom_range(0, 15) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
            end else if (r < 16) begin
                a_tmp = a_tmp + 4; addr = a_tmp[31:2]; we = 1'b1; wdata = $urandom_range(0, 12);
            end else if (r < 22) begin
                a_tmp = a_tmp + 12; addr = a_tmp[31:2]; we = 1'b1; wdata = $urandom_range(0, 1);
            end else if (r < 25) begin
                a_tmp = pick_addr(); addr = a_tmp[31:2]; we = 1'b1; wdata = $urandom_range(0, 15);
            end else begin
                a_tmp = pick_addr(); addr = a_tmp[31:2];
            end
            if (c == 1500) begin
                #2 reset = 1'b0;
                #1;
                check("rnd_rst_irq", 32'(irq), 0);
                check("rnd_rst_any", 32'(irq_any), 0);
                #8 reset = 1'b1;
            end
            tick();
        end
        we = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
